// File: rtl/tt_sel_pkg.sv
// Shared types and default sizing for the design-select sequencer.
package tt_sel_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int HALF_W_DEF   = 4;
    localparam int HALF_CYC_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        DIS,
        RST,
        REL,
        INC_H,
        INC_L,
        ENA
    } sel_state_e;

endpackage

// File: rtl/tt_sel_phase_tmr.sv
// Half-phase timer: reloads HALF_CYC-1 whenever the sequencer changes state,
// expire is high on the last cycle of the phase.
module tt_sel_phase_tmr #(
    parameter int HALF_W   = 4,
    parameter int HALF_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam logic [HALF_W-1:0] RELOAD = HALF_W'(HALF_CYC - 1);

    logic [HALF_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= RELOAD;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// Design-select sequencer: DIS -> RST -> REL -> N inc pulses -> ENA.
// Define TT_SEL_SEQ_INCR_EN to step upward from the active selection without a select reset.
module tt_sel_seq
    import tt_sel_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int HALF_W   = HALF_W_DEF,
    parameter int HALF_CYC = HALF_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              sel_valid,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    sel_state_e        state;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] cnt;
    logic              hs;
    logic              adv;
    logic              expire;
`ifdef TT_SEL_SEQ_INCR_EN
    logic              incr;
`endif

    assign hs        = req_valid && (state == IDLE);
    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // Timed phases leave on expire; IDLE leaves on handshake, ENA after one cycle.
    always_comb begin
        adv = 1'b0;
        case (state)
            IDLE:    adv = hs;
            ENA:     adv = 1'b1;
            default: adv = expire;
        endcase
    end

    tt_sel_phase_tmr #(
        .HALF_W   (HALF_W),
        .HALF_CYC (HALF_CYC)
    ) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .load   (adv),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tgt            <= '0;
            cnt            <= '0;
            done           <= 1'b0;
            cur_addr       <= '0;
            sel_valid      <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
`ifdef TT_SEL_SEQ_INCR_EN
            incr           <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (adv) begin
                case (state)
                    IDLE: begin
                        tgt       <= req_addr;
                        sel_valid <= 1'b0;
                        ctrl_ena  <= 1'b0;
                        state     <= DIS;
`ifdef TT_SEL_SEQ_INCR_EN
                        // Counting from cur_addr yields exactly req_addr-cur_addr pulses.
                        if (sel_valid && (req_addr >= cur_addr)) begin
                            incr <= 1'b1;
                            cnt  <= cur_addr;
                        end else begin
                            incr <= 1'b0;
                        end
`endif
                    end
                    DIS: begin
`ifdef TT_SEL_SEQ_INCR_EN
                        if (incr) begin
                            if (cnt == tgt) begin
                                state     <= ENA;
                                ctrl_ena  <= 1'b1;
                                done      <= 1'b1;
                                sel_valid <= 1'b1;
                                cur_addr  <= tgt;
                            end else begin
                                state        <= INC_H;
                                ctrl_sel_inc <= 1'b1;
                            end
                        end else begin
                            state          <= RST;
                            ctrl_sel_rst_n <= 1'b0;
                        end
`else
                        state          <= RST;
                        ctrl_sel_rst_n <= 1'b0;
`endif
                    end
                    RST: begin
                        state          <= REL;
                        ctrl_sel_rst_n <= 1'b1;
                        cnt            <= '0;
                    end
                    REL: begin
                        if (tgt == '0) begin
                            state     <= ENA;
                            ctrl_ena  <= 1'b1;
                            done      <= 1'b1;
                            sel_valid <= 1'b1;
                            cur_addr  <= tgt;
                        end else begin
                            state        <= INC_H;
                            ctrl_sel_inc <= 1'b1;
                        end
                    end
                    INC_H: begin
                        state        <= INC_L;
                        ctrl_sel_inc <= 1'b0;
                        cnt          <= cnt + 1'b1;
                    end
                    INC_L: begin
                        if (cnt == tgt) begin
                            state     <= ENA;
                            ctrl_ena  <= 1'b1;
                            done      <= 1'b1;
                            sel_valid <= 1'b1;
                            cur_addr  <= tgt;
                        end else begin
                            state        <= INC_H;
                            ctrl_sel_inc <= 1'b1;
                        end
                    end
                    ENA:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_sel_seq.sv
// Directed bench for tt_sel_seq with a scoreboard of expected selections.
module tb_tt_sel_seq;

    localparam int ADDR_W = 10;
    localparam int HALF_W = 4;
    localparam int H      = 4;
`ifdef TT_SEL_SEQ_INCR_EN
    localparam bit INCR = 1'b1;
`else
    localparam bit INCR = 1'b0;
`endif

    typedef struct {
        int addr;
        int n;
        int lat;
        bit full;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_ready, busy, done, sel_valid;
    logic              ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
    logic [ADDR_W-1:0] cur_addr;

    tt_sel_seq #(.ADDR_W(ADDR_W), .HALF_W(HALF_W), .HALF_CYC(H)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .busy           (busy),
        .done           (done),
        .cur_addr       (cur_addr),
        .sel_valid      (sel_valid),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   m_cur = 0;
    bit   m_valid = 1'b0;

    // Monitor: samples on the falling edge, away from the active edge.
    int cyc = 0, hs_cyc = 0, hs_cnt = 0, done_cnt = 0, pulses = 0, hi_run = 0;
    bit inc_prev = 1'b0, bad_hi = 1'b0, rst_low = 1'b0;
    int m_lat = 0, m_pulses = 0;
    bit m_bad = 1'b0, m_rstlow = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (req_valid && req_ready) begin
            hs_cyc  = cyc;
            hs_cnt++;
            pulses  = 0;
            hi_run  = 0;
            bad_hi  = 1'b0;
            rst_low = 1'b0;
        end
        if (ctrl_sel_inc && !inc_prev) pulses++;
        if (ctrl_sel_inc) hi_run++;
        else if (inc_prev) begin
            if (hi_run != H) bad_hi = 1'b1;
            hi_run = 0;
        end
        if (!ctrl_sel_rst_n) rst_low = 1'b1;
        if (done) begin
            done_cnt++;
            m_lat    = cyc - hs_cyc;
            m_pulses = pulses;
            m_bad    = bad_hi;
            m_rstlow = rst_low;
        end
        inc_prev = ctrl_sel_inc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int a);
        exp_t e;
        e.addr = a;
        e.full = !(INCR && m_valid && (a >= m_cur));
        e.n    = e.full ? a : a - m_cur;
        e.lat  = e.full ? (3 + 2 * e.n) * H + 1 : (1 + 2 * e.n) * H + 1;
        m_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_hs(input int prev, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (hs_cnt != prev) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_hs"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int   prev = done_cnt;
        bit   ok = 1'b0;
        exp_t e;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            if (done_cnt != prev) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (!ok) return;
        chk({tag, "_latency"}, 32'(m_lat), 32'(e.lat));
        chk({tag, "_pulses"}, 32'(m_pulses), 32'(e.n));
        chk({tag, "_high_len"}, 32'(m_bad), 32'd0);
        chk({tag, "_rst_phase"}, 32'(m_rstlow), 32'(e.full));
        chk({tag, "_cur_addr"}, 32'(cur_addr), 32'(e.addr));
        chk({tag, "_sel_valid"}, 32'(sel_valid), 32'd1);
        chk({tag, "_ena"}, 32'(ctrl_ena), 32'd1);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        m_cur   = e.addr;
        m_valid = 1'b1;
    endtask

    task automatic sel(input int a, input string tag);
        int prev = hs_cnt;
        req_addr  = ADDR_W'(a);
        req_valid = 1'b1;
        wait_hs(prev, tag);
        push_exp(a);
        req_valid = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        int h1;
        int prev;
        bit seen;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
        chk("rst_cur", 32'(cur_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
        chk("post_rst_ena", 32'(ctrl_ena), 32'd0);
        repeat (100) @(negedge clk);
        chk("idle_no_inc", 32'(pulses), 32'd0);
        chk("idle_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
        @(posedge clk); #1;

        sel(3, "sel3");
        sel(0, "sel0");
        sel(1023, "sel1023");

        // req_valid held through the sequence; busy-time addresses are ignored
        prev      = hs_cnt;
        req_addr  = 10'd2;
        req_valid = 1'b1;
        wait_hs(prev, "hold2");
        push_exp(2);
        req_addr = 10'd5;
        repeat (10) begin @(posedge clk); #1; end
        req_addr = 10'd1;
        h1 = hs_cnt;
        wait_done("hold2");
        chk("hold_no_early_hs", 32'(hs_cnt), 32'(h1));
        wait_hs(h1, "hold1");
        push_exp(1);
        req_valid = 1'b0;
        wait_done("hold1");

        // Asynchronous reset in the middle of an increment pulse
        prev      = hs_cnt;
        req_addr  = 10'd5;
        req_valid = 1'b1;
        wait_hs(prev, "mid5");
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (ctrl_sel_inc) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_inc_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_inc", 32'(ctrl_sel_inc), 32'd0);
        chk("mid_rst_ena", 32'(ctrl_ena), 32'd0);
        chk("mid_rst_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
        chk("mid_rst_valid", 32'(sel_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cur", 32'(cur_addr), 32'd0);
        m_cur   = 0;
        m_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sel(2, "after_rst2");

        // Upward / downward reselection
        sel(4, "sel4");
        sel(6, "sel6");
        sel(2, "sel2_down");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
